mem_port_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port memory controller between `NUM_REQ` HLS-generated kernels (e.g. `memset` plus a string-processing kernel). It selects one requester per cycle, drives the shared memory port, and routes the one-cycle-latency read data back with a per-requester valid pulse. An optional lock lets a kernel hold the port for a loop, bounded by a watchdog.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_port_arbiter_if.sv | 34 +++
 rtl/rr_priority_pick.sv | 37 +++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter and its round-robin picker.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned MAX_NUM_REQ = 8;

  // Requester index; wide enough for MAX_NUM_REQ requesters.
  typedef logic [2:0] req_idx_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Kernel/memory side bundle of the arbiter. The master side is the kernels plus the
// memory controller; the slave side is the arbiter itself.
interface mem_port_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = mem_arb_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W  = mem_arb_pkg::DEF_DATA_W
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;

    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;

    modport master (
        output req, we, lock, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req, we, lock, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational find-first-set over req, starting at ptr and wrapping around.
// Produces a one-hot grant and its encoded index; ptr must be below N.
module rr_priority_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0] req,
    input  req_idx_t     ptr,
    output logic [N-1:0] gnt_oh,
    output req_idx_t     idx,
    output logic         valid
);

    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        gnt_oh = '0;
        // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i] && (req_idx_t'(i) >= ptr)) begin
                valid = 1'b1;
                idx   = req_idx_t'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i]) begin
                valid = 1'b1;
                idx   = req_idx_t'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            gnt_oh[i] = valid && (idx == req_idx_t'(i));
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_REQ kernels, with an
// optional watchdog-bounded lock and one-cycle read-data return.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned MAX_LOCK = 16
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned CntW = clog2(MAX_LOCK + 1);
    typedef logic [CntW-1:0] cnt_t;

    if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ) begin : g_bad_num_req
        $error("NUM_REQ out of range");
    end

    req_idx_t           ptr_q, ptr_d;
    req_idx_t           owner_q, owner_d;
    logic               owner_v_q, owner_v_d;
    cnt_t               lock_cnt_q, lock_cnt_d;
    logic [NUM_REQ-1:0] rd_pend_q;

    logic [NUM_REQ-1:0] pick_oh, owner_oh, gnt;
    req_idx_t           pick_idx, gnt_idx, next_ptr;
    logic               pick_valid, owner_req, locked, mem_en;
    logic               gnt_we, gnt_lock;
    cnt_t               cnt_inc;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    rr_priority_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .gnt_oh (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    always_comb begin
        owner_req = 1'b0;
        owner_oh  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == req_idx_t'(i)) begin
                owner_req   = bus.req[i];
                owner_oh[i] = 1'b1;
            end
        end
        // A lock only holds while its owner keeps requesting.
        locked  = owner_v_q && owner_req;
        gnt     = locked ? owner_oh : pick_oh;
        gnt_idx = locked ? owner_q : pick_idx;
        mem_en  = locked || pick_valid;

        sel_addr  = '0;
        sel_wdata = '0;
        gnt_we    = 1'b0;
        gnt_lock  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr  = bus.addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.wdata[i*DATA_W +: DATA_W];
                gnt_we    = bus.we[i];
                gnt_lock  = bus.lock[i];
            end
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        owner_v_d  = owner_v_q;
        lock_cnt_d = lock_cnt_q;
        next_ptr   = (gnt_idx == req_idx_t'(NUM_REQ - 1)) ? '0 : gnt_idx + req_idx_t'(1);
        cnt_inc    = locked ? lock_cnt_q + cnt_t'(1) : cnt_t'(1);

        if (owner_v_q && !owner_req) begin
            owner_v_d  = 1'b0;
            lock_cnt_d = '0;
        end

        if (mem_en) begin
            if (!gnt_lock) begin
                ptr_d      = next_ptr;
                owner_v_d  = 1'b0;
                lock_cnt_d = '0;
            end else if (cnt_inc == cnt_t'(MAX_LOCK)) begin
                // Watchdog: force the owner to give up the port next cycle.
                owner_d    = gnt_idx;
                owner_v_d  = 1'b0;
                lock_cnt_d = '0;
                ptr_d      = next_ptr;
            end else begin
                owner_d    = gnt_idx;
                owner_v_d  = 1'b1;
                lock_cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= '0;
            owner_q    <= '0;
            owner_v_q  <= 1'b0;
            lock_cnt_q <= '0;
            rd_pend_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            owner_v_q  <= owner_v_d;
            lock_cnt_q <= lock_cnt_d;
            rd_pend_q  <= gnt & ~bus.we;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_en && gnt_we;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;
    assign bus.rvalid    = rd_pend_q;
    assign bus.rdata     = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a default-lock instance plus a MAX_LOCK=3
// instance sharing the same requester stimulus.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    mem_port_arbiter_if #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32)) bus ();
    mem_port_arbiter_if #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32)) bus_w ();

    mem_port_arbiter #(
        .NUM_REQ  (2),
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_LOCK (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mem_port_arbiter #(
        .NUM_REQ  (2),
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_LOCK (3)
    ) dut_w (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_w)
    );

    assign bus_w.req       = bus.req;
    assign bus_w.we        = bus.we;
    assign bus_w.lock      = bus.lock;
    assign bus_w.addr      = bus.addr;
    assign bus_w.wdata     = bus.wdata;
    assign bus_w.mem_rdata = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency memory model for the main instance.
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
        if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr[3:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive at the falling edge, then let combinational outputs settle.
    task automatic apply(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l);
        @(negedge clk);
        bus.req  = r;
        bus.we   = w;
        bus.lock = l;
        #1;
    endtask

    logic [1:0] rr_exp [6];
    logic [1:0] wd_exp [5];

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h100 + i;
        mem[5] = 32'hA5;
        rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        wd_exp = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01};

        reset         = 1'b1;
        bus.req       = '0;
        bus.we        = '0;
        bus.lock      = '0;
        bus.addr      = {32'd5, 32'd1};
        bus.wdata     = '0;
        bus.mem_rdata = '0;
        repeat (2) begin
            @(negedge clk);
            bus.req = 2'($urandom);
        end

        // Reset release with no requests
        @(negedge clk);
        reset   = 1'b0;
        bus.req = '0;
        #1;
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_rvalid", 32'(bus.rvalid), 32'h0);
        check("rst_mem_en", 32'(bus.mem_en), 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);

        // Round robin, all reads
        for (int k = 0; k < 6; k++) begin
            apply(2'b11, 2'b00, 2'b00);
            check($sformatf("rr_gnt%0d", k), 32'(bus.gnt), 32'(rr_exp[k]));
            check($sformatf("rr_rvalid%0d", k), 32'(bus.rvalid),
                  (k == 0) ? 32'h0 : 32'(rr_exp[k-1]));
        end
        check("rr_mem_addr", bus.mem_addr, 32'd5);

        // Read return from address 5 by requester 1
        apply(2'b10, 2'b00, 2'b00);
        check("rd_gnt", 32'(bus.gnt), 32'h2);
        check("rd_mem_addr", bus.mem_addr, 32'd5);
        check("rd_mem_we", 32'(bus.mem_we), 32'h0);

        // Write 0x77 to address 3 by requester 0
        bus.addr  = {32'd5, 32'd3};
        bus.wdata = {32'h0, 32'h77};
        apply(2'b01, 2'b01, 2'b00);
        check("rd_rvalid", 32'(bus.rvalid), 32'h2);
        check("rd_rdata", bus.rdata, 32'hA5);
        check("wr_gnt", 32'(bus.gnt), 32'h1);
        check("wr_mem_we", 32'(bus.mem_we), 32'h1);
        check("wr_mem_wdata", bus.mem_wdata, 32'h77);
        check("wr_mem_addr", bus.mem_addr, 32'd3);

        apply(2'b01, 2'b00, 2'b00);
        check("wr_no_rvalid", 32'(bus.rvalid), 32'h0);
        check("rb_gnt", 32'(bus.gnt), 32'h1);

        apply(2'b10, 2'b00, 2'b00);
        check("rb_rvalid", 32'(bus.rvalid), 32'h1);
        check("rb_rdata", bus.rdata, 32'h77);
        check("rb2_gnt", 32'(bus.gnt), 32'h2);

        // Lock hold by requester 0 for four grants, then release
        for (int k = 0; k < 4; k++) begin
            apply(2'b11, 2'b00, 2'b01);
            check($sformatf("lk_gnt%0d", k), 32'(bus.gnt), 32'h1);
        end
        apply(2'b11, 2'b00, 2'b00);
        check("lk_last_gnt", 32'(bus.gnt), 32'h1);
        apply(2'b11, 2'b00, 2'b00);
        check("lk_after_gnt", 32'(bus.gnt), 32'h2);

        // Owner withdraws while requester 1 requests
        apply(2'b11, 2'b00, 2'b01);
        check("wd0_gnt", 32'(bus.gnt), 32'h1);
        apply(2'b10, 2'b00, 2'b00);
        check("wd0_drop_gnt", 32'(bus.gnt), 32'h2);
        apply(2'b11, 2'b00, 2'b00);
        check("wd0_next_gnt", 32'(bus.gnt), 32'h1);

        // Mid-lock reset with a read in flight
        apply(2'b01, 2'b00, 2'b01);
        check("ml_gnt", 32'(bus.gnt), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        bus.req  = '0;
        bus.lock = '0;
        #1;
        check("ml_rvalid", 32'(bus.rvalid), 32'h0);
        check("ml_gnt_idle", 32'(bus.gnt), 32'h0);
        check("ml_mem_en", 32'(bus.mem_en), 32'h0);
        apply(2'b11, 2'b00, 2'b00);
        check("ml_ptr_gnt", 32'(bus.gnt), 32'h1);
        apply(2'b10, 2'b00, 2'b00);
        check("ml_gnt1", 32'(bus.gnt), 32'h2);

        // Watchdog on the MAX_LOCK=3 instance; default instance keeps the lock
        for (int k = 0; k < 5; k++) begin
            apply(2'b11, 2'b00, 2'b01);
            check($sformatf("wdog_gnt%0d", k), 32'(bus_w.gnt), 32'(wd_exp[k]));
            check($sformatf("nowdog_gnt%0d", k), 32'(bus.gnt), 32'h1);
        end

        apply(2'b00, 2'b00, 2'b00);
        check("end_gnt", 32'(bus.gnt), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
